otfs_qam4_demapper: RTL and testbench

- Sits directly downstream of the OTFS receive demodulator.
- Takes the 64x64 FFT output stream (24-bit signed Re/Im per bin, no backpressure) and makes a 4QAM hard decision per sample.
- Buffers one full frame of decided symbols and reads it out in transposed (delay-Doppler) order, packed 4 symbols per byte, on a valid/ready byte stream to the bit sink.

---
 rtl/otfs_qam4_demapper.sv | 204 ++++++++++++++++++++
 tb/tb_otfs_qam4_demapper.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/otfs_qam4_demapper.sv
// rtl/otfs_qam4_demapper.sv - 4QAM hard-decision demapper with full-frame transposing buffer
//
// Purpose:
//   Takes the N_BINS x M_FRAMES OTFS FFT output stream (signed Re/Im, no
//   backpressure). It makes a sign-based 4QAM decision per sample and
//   collects one frame. It then replays the frame in delay-Doppler order:
//   bin index b outer, sub-frame index f inner. Four symbols are packed per
//   byte, with the first-read symbol in bits [1:0].
//
// Ports:
//   Clk        rising-edge clock
//   Arstn      asynchronous active-low reset
//   Start      one-cycle pulse, arms collection of one frame (IDLE only)
//   InValid    input sample strobe
//   InRe/InIm  signed DATA_W-bit sample
//   OutData    packed symbols, symbol 0 in [1:0]
//   OutValid   OutData valid
//   OutReady   sink accepts OutData
//   OutLast    final byte of the frame
//   Busy       high in COLLECT or DRAIN
//   Overflow   sticky, set when a sample arrives during DRAIN
//   ErasureCnt low-magnitude sample count (only with OTFS_DEMAP_STATS_EN)
//
// Optional feature macro: OTFS_DEMAP_STATS_EN
//
// Parameter constraints: N_BINS and M_FRAMES are powers of two, and
// M_FRAMES >= 8.

module otfs_qam4_demapper #(
    parameter int N_BINS    = 64,
    parameter int M_FRAMES  = 64,
    parameter int DATA_W    = 24,
    parameter int ERASE_THR = 256
) (
    input  logic              Clk,
    input  logic              Arstn,
    input  logic              Start,
    input  logic              InValid,
    input  logic [DATA_W-1:0] InRe,
    input  logic [DATA_W-1:0] InIm,
    output logic [7:0]        OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              OutLast,
    output logic              Busy,
    output logic              Overflow
`ifdef OTFS_DEMAP_STATS_EN
    ,
    output logic [15:0]       ErasureCnt
`endif
);

    localparam int DEPTH = N_BINS * M_FRAMES;
    localparam int WORDS = DEPTH / 4;
    localparam int AW    = $clog2(DEPTH);
    localparam int NB    = $clog2(N_BINS);
    localparam int MB    = $clog2(M_FRAMES);
    localparam int WAW   = AW - 2;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t         state;
    logic [AW-1:0]  wr_cnt;
    logic [WAW-1:0] rd_cnt;
    logic           rd_pend;
    logic           rd_vld;
    logic           rd_last;
    logic [7:0]     rd_q;

    // The frame buffer is organised as WORDS x 8 bits. Each word holds the
    // four symbols of sub-frames 4q..4q+3 at one bin, with lane = f[1:0].
    // A single read then returns a fully packed output byte. This sustains
    // one byte per cycle while keeping a single write and a single read
    // port.
    logic [7:0] mem [WORDS];

    logic [1:0]     sym;
    logic           wr_en;
    logic [WAW-1:0] wr_word;
    logic [1:0]     wr_lane;
    logic [WAW-1:0] rd_word;
    logic           consume;
    logic           issue;

    assign sym     = {InIm[DATA_W-1], InRe[DATA_W-1]};
    assign wr_en   = (state == S_COLLECT) && InValid;
    // wr_cnt = {f, b}; word = {f[MB-1:2], b}; lane = f[1:0]
    assign wr_word = {wr_cnt[AW-1:NB+2], wr_cnt[NB-1:0]};
    assign wr_lane = wr_cnt[NB+1:NB];
    // rd_cnt = {b, fq}, so fq is the fast (inner) index; word = {fq, b}
    assign rd_word = {rd_cnt[MB-3:0], rd_cnt[WAW-1:MB-2]};

    // The read holding register advances only when its word can move into
    // the output register. A stalled sink therefore freezes the prefetch
    // without losing or repeating a word.
    assign consume = rd_vld && (!OutValid || OutReady);
    assign issue   = (state == S_DRAIN) && rd_pend && (!rd_vld || consume);

    assign Busy = (state != S_IDLE);

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_word][{wr_lane, 1'b0} +: 2] <= sym;
        end
        if (issue) begin
            rd_q <= mem[rd_word];
        end
    end

    always_ff @(posedge Clk or negedge Arstn) begin
        if (!Arstn) begin
            state    <= S_IDLE;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            rd_pend  <= 1'b0;
            rd_vld   <= 1'b0;
            rd_last  <= 1'b0;
            OutData  <= 8'h00;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state  <= S_COLLECT;
                        wr_cnt <= '0;
                    end
                end
                S_COLLECT: begin
                    if (InValid) begin
                        if (wr_cnt == AW'(DEPTH - 1)) begin
                            state   <= S_DRAIN;
                            rd_cnt  <= '0;
                            rd_pend <= 1'b1;
                            rd_vld  <= 1'b0;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (InValid) begin
                        Overflow <= 1'b1;
                    end
                    if (issue) begin
                        rd_last <= (rd_cnt == WAW'(WORDS - 1));
                        if (rd_cnt == WAW'(WORDS - 1)) begin
                            rd_pend <= 1'b0;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                    if (issue) begin
                        rd_vld <= 1'b1;
                    end else if (consume) begin
                        rd_vld <= 1'b0;
                    end
                    if (consume) begin
                        OutData  <= rd_q;
                        OutValid <= 1'b1;
                        OutLast  <= rd_last;
                    end else if (OutValid && OutReady) begin
                        OutValid <= 1'b0;
                        OutLast  <= 1'b0;
                        if (OutLast) begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef OTFS_DEMAP_STATS_EN
    // Sign-extend by one bit so that the threshold comparison is exact.
    // The most-negative input then lies far below -THR and never counts.
    localparam logic signed [DATA_W:0] THR = (DATA_W + 1)'(ERASE_THR);

    logic signed [DATA_W:0] re_x;
    logic signed [DATA_W:0] im_x;
    logic                   erase;

    assign re_x  = {InRe[DATA_W-1], InRe};
    assign im_x  = {InIm[DATA_W-1], InIm};
    assign erase = ((re_x > -THR) && (re_x < THR)) ||
                   ((im_x > -THR) && (im_x < THR));

    always_ff @(posedge Clk or negedge Arstn) begin
        if (!Arstn) begin
            ErasureCnt <= 16'h0000;
        end else if ((state == S_IDLE) && Start) begin
            ErasureCnt <= 16'h0000;
        end else if (wr_en && erase && (ErasureCnt != 16'hFFFF)) begin
            ErasureCnt <= ErasureCnt + 16'h0001;
        end
    end
`else
    logic unused_mag;
    assign unused_mag = ^{InRe[DATA_W-2:0], InIm[DATA_W-2:0]};
`endif

endmodule

// File: tb/tb_otfs_qam4_demapper.sv
// tb/tb_otfs_qam4_demapper.sv - self-checking bench for otfs_qam4_demapper
module tb_otfs_qam4_demapper;

    localparam int N_BINS   = 64;
    localparam int M_FRAMES = 64;
    localparam int DATA_W   = 24;
    localparam int DEPTH    = N_BINS * M_FRAMES;
    localparam int NBYTES   = DEPTH / 4;

    localparam logic [DATA_W-1:0] P1K  = DATA_W'(1000);
    localparam logic [DATA_W-1:0] N1K  = DATA_W'(-1000);
    localparam logic [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MINN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] NEG1 = {DATA_W{1'b1}};

    logic              Clk = 1'b0;
    logic              Arstn = 1'b0;
    logic              Start = 1'b0;
    logic              InValid = 1'b0;
    logic [DATA_W-1:0] InRe = '0;
    logic [DATA_W-1:0] InIm = '0;
    logic              OutReady = 1'b0;
    logic [7:0]        OutData;
    logic              OutValid;
    logic              OutLast;
    logic              Busy;
    logic              Overflow;
`ifdef OTFS_DEMAP_STATS_EN
    logic [15:0]       ErasureCnt;
`endif

    always #5 Clk = ~Clk;

    otfs_qam4_demapper #(
        .N_BINS(N_BINS), .M_FRAMES(M_FRAMES), .DATA_W(DATA_W), .ERASE_THR(256)
    ) dut (
        .Clk(Clk),
        .Arstn(Arstn),
        .Start(Start),
        .InValid(InValid),
        .InRe(InRe),
        .InIm(InIm),
        .OutData(OutData),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .OutLast(OutLast),
        .Busy(Busy),
        .Overflow(Overflow)
`ifdef OTFS_DEMAP_STATS_EN
        ,
        .ErasureCnt(ErasureCnt)
`endif
    );

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic [1:0]        sym;
    } vec_t;

    vec_t       tbl[8];
    logic [1:0] sym_arr[DEPTH];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic gen(input int mode, input int k,
                       output logic [DATA_W-1:0] re, output logic [DATA_W-1:0] im);
        re = k[0] ? N1K : P1K;
        im = k[6] ? N1K : P1K;
        case (mode)
            0: begin re = P1K; im = N1K; end
            2: begin re = tbl[(k + k / 64) % 8].re; im = tbl[(k + k / 64) % 8].im; end
            3: begin
                if (k < 100) re = DATA_W'(10);
                else if (k == 100) re = MINN;
            end
            default: ;
        endcase
    endtask

    task automatic send_start();
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        chk("busy_after_start", Busy, 1);
    endtask

    task automatic drive_frame(input int mode, input int stop_at);
        logic [DATA_W-1:0] re, im;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == stop_at) break;
            gen(mode, k, re, im);
            if (mode == 2) sym_arr[k] = tbl[(k + k / 64) % 8].sym;
            else           sym_arr[k] = {$signed(im) < 0, $signed(re) < 0};
            if (mode == 1 && k % 7 == 3) begin
                @(negedge Clk); InValid = 1'b0;
            end
            @(negedge Clk);
            InValid = 1'b1; InRe = re; InIm = im;
            Start = (mode == 1 && k == 1000);
        end
        @(negedge Clk); InValid = 1'b0; Start = 1'b0;
    endtask

    task automatic build_expected();
        exp_q.delete();
        for (int b = 0; b < N_BINS; b++)
            for (int fq = 0; fq < M_FRAMES / 4; fq++)
                exp_q.push_back({sym_arr[(4*fq+3)*N_BINS+b], sym_arr[(4*fq+2)*N_BINS+b],
                                 sym_arr[(4*fq+1)*N_BINS+b], sym_arr[(4*fq)*N_BINS+b]});
    endtask

    task automatic drain(input string tag, input int rdy_pct, input int ovf_every, input int stop_after);
        int         cyc = 0;
        int         got = 0;
        int         target;
        logic       stalled = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] e;
        target = (stop_after > 0) ? stop_after : NBYTES;
        while (got < target && cyc < 20000) begin
            @(negedge Clk); cyc++;
            if (stalled) begin
                chk({tag, "_stall_data"}, OutData, held);
                chk({tag, "_stall_valid"}, OutValid, 1);
            end
            InValid  = (ovf_every > 0) && (cyc % ovf_every == 0);
            OutReady = ($urandom_range(99) < rdy_pct);
            if (OutValid && OutReady) begin
                e = exp_q.pop_front();
                chk({tag, "_data"}, OutData, e);
                chk({tag, "_last"}, OutLast, got == NBYTES - 1);
                got++;
            end
            stalled = OutValid && !OutReady;
            held    = OutData;
        end
        InValid = 1'b0;
        if (got < target) chk({tag, "_timeout"}, got, target);
        if (stop_after == 0) begin
            if (rdy_pct == 100) chk({tag, "_throughput"}, cyc <= NBYTES + 6, 1);
            @(negedge Clk); OutReady = 1'b0;
            chk({tag, "_end_valid"}, OutValid, 0);
            chk({tag, "_end_last"}, OutLast, 0);
            chk({tag, "_end_idle"}, Busy, 0);
            chk({tag, "_sb_empty"}, exp_q.size(), 0);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        Arstn = 1'b0; InValid = 1'b0; Start = 1'b0; OutReady = 1'b0;
        #1;
        chk({tag, "_data"}, OutData, 0);
        chk({tag, "_valid"}, OutValid, 0);
        chk({tag, "_last"}, OutLast, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_ovf"}, Overflow, 0);
        @(negedge Clk); Arstn = 1'b1;
    endtask

    initial begin
        tbl[0] = '{re: '0,            im: '0,            sym: 2'd0};
        tbl[1] = '{re: NEG1,          im: '0,            sym: 2'd1};
        tbl[2] = '{re: '0,            im: NEG1,          sym: 2'd2};
        tbl[3] = '{re: NEG1,          im: NEG1,          sym: 2'd3};
        tbl[4] = '{re: MAXP,          im: MINN,          sym: 2'd2};
        tbl[5] = '{re: MINN,          im: MAXP,          sym: 2'd1};
        tbl[6] = '{re: DATA_W'(1),    im: DATA_W'(1),    sym: 2'd0};
        tbl[7] = '{re: MINN + 1'b1,   im: DATA_W'(-5),   sym: 2'd3};

        repeat (3) @(negedge Clk);
        chk("rst_data", OutData, 0);
        chk("rst_valid", OutValid, 0);
        chk("rst_last", OutLast, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_ovf", Overflow, 0);
        Arstn = 1'b1;

        @(negedge Clk); InValid = 1'b1; InRe = N1K; InIm = N1K;
        repeat (5) @(negedge Clk);
        InValid = 1'b0;
        @(negedge Clk);
        chk("idle_invalid_ovf", Overflow, 0);
        chk("idle_invalid_busy", Busy, 0);

        send_start(); drive_frame(0, -1); build_expected(); drain("const", 100, 0, 0);
        chk("const_ovf", Overflow, 0);

        send_start(); drive_frame(1, -1); build_expected(); drain("pat", 100, 0, 0);

        send_start(); drive_frame(1, -1); build_expected(); drain("pat_stall", 50, 0, 0);

        send_start(); drive_frame(2, -1); build_expected(); drain("tbl_ovf", 100, 37, 0);
        chk("ovf_set", Overflow, 1);

        send_start(); drive_frame(1, -1); build_expected(); drain("ovf_sticky", 70, 0, 0);
        chk("ovf_held", Overflow, 1);

        send_start(); drive_frame(1, -1); build_expected(); drain("mid_drain", 100, 0, 500);
        do_reset("rst_drain");
        send_start(); drive_frame(0, -1); build_expected(); drain("after_rst_d", 100, 0, 0);

        send_start(); drive_frame(1, 2000);
        do_reset("rst_collect");
        send_start(); drive_frame(1, -1); build_expected(); drain("after_rst_c", 100, 0, 0);
        chk("after_rst_ovf", Overflow, 0);

`ifdef OTFS_DEMAP_STATS_EN
        send_start(); drive_frame(3, -1); build_expected(); drain("stats", 100, 0, 0);
        chk("erasure_cnt", ErasureCnt, 100);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
